// File: rtl/mux_pkg.sv
// Shared mode encodings and select-width helper for the registered N-way mux.
// No logic, no latency.
// No flow control.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // A single-bit index is kept even for N<=2 so port widths never collapse to zero.
    function automatic int calc_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requests, searching upward from the rotating pointer.
// Grant is combinational; the pointer moves on the clock edge after an accepted grant.
// The pointer holds unless advance is asserted, so a stalled grant keeps its priority.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = calc_sel_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [SEL_W-1:0] rr_ptr;

    // Channel visited i steps after the pointer, wrapping at N (pointer is always < N).
    function automatic logic [SEL_W-1:0] idx_at(input logic [SEL_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N) begin
            s = s - N;
        end
        return SEL_W'(s);
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && req[idx_at(rr_ptr, i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_at(rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-input registered mux: external select or round-robin, one output register stage.
// Latency 1 cycle from input handshake to out_valid; 1 beat/cycle when out_ready stays high.
// Output register reloads only when empty or draining; in_ready follows out_ready combinationally.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = calc_sel_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int PAD_W = 1 << SEL_W;

    logic             load_en;
    logic             transfer;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_vld;
    logic [PAD_W-1:0] vld_pad;

    // Padding lets an out-of-range sel index safely; the range test rejects it anyway.
    assign vld_pad = PAD_W'(in_valid);
    assign sel_vld = (int'(sel) < N) && vld_pad[sel];

    always_comb begin
        gnt_vld = sel_vld;
        gnt_idx = sel;
        if (mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end
    end

    // No handshake while in reset: the register would discard the beat.
    assign load_en  = rst_n && (!out_valid || out_ready);
    assign transfer = load_en && gnt_vld;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = transfer && (gnt_idx == SEL_W'(k));
        end
    end

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (transfer && (mode == MODE_RR)),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_sel  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a 4-channel instance and a 3-channel instance on one clock.
module tb_rr_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-channel instance
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    // 3-channel instance
    logic         rst3_n;
    logic         mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;
    logic         out_ready3;

    rr_mux_n #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux_n #(.WIDTH(32), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
        chk({tag, "_data"},  out_data,       d);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        rst3_n     = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd3;
        in_data3   = {32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;

        // Reset held two cycles with every channel valid
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);

        // Round-robin from rr_ptr=0, all valid, consumer always ready
        rst_n = 1'b1;
        #1;
        chk("rr_first_grant", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 8; i++) begin
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
            step();
            chk_out("rr_seq", 1'b1, 2'(i % 4), 32'hCAFE_0000 + 32'(i % 4));
        end

        // One more beat on ch0 leaves rr_ptr=1, then only ch3 and ch0 request
        step();
        chk_out("rr_ptr1", 1'b1, 2'd0, 32'hCAFE_0000);
        in_valid = 4'b1001;
        #1;
        chk("rr_sparse_ready3", 32'(in_ready), 32'b1000);
        step();
        chk_out("rr_sparse_beat3", 1'b1, 2'd3, 32'hCAFE_0003);
        chk("rr_sparse_ready0", 32'(in_ready), 32'b0001);
        step();
        chk_out("rr_sparse_beat0", 1'b1, 2'd0, 32'hCAFE_0000);

        // Backpressure: beat A (ch0) held for 3 cycles, rr_ptr stays at 1
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("bp_hold", 1'b1, 2'd0, 32'hCAFE_0000);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        step();
        chk_out("bp_next", 1'b1, 2'd1, 32'hCAFE_0001);

        // External select of ch2 (rr_ptr now 2 and must hold in this mode)
        mode = 1'b0;
        sel  = 2'd2;
        #1;
        chk("sel2_ready", 32'(in_ready), 32'b0100);
        step();
        chk_out("sel2_beat", 1'b1, 2'd2, 32'hCAFE_0002);
        chk("sel2_ready_again", 32'(in_ready), 32'b0100);
        step();
        chk_out("sel2_beat2", 1'b1, 2'd2, 32'hCAFE_0002);

        // Selected channel not valid: no grant, no skipping, output drains
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        chk("sel1_noready", 32'(in_ready), 32'h0);
        step();
        chk_out("sel1_drain", 1'b0, 2'd2, 32'hCAFE_0002);

        // Load a ch0 beat in select mode, then switch to RR mid-stream
        sel      = 2'd0;
        in_valid = 4'b0001;
        step();
        chk_out("sel0_beat", 1'b1, 2'd0, 32'hCAFE_0000);
        mode     = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("switch_rr_ptr2", 32'(in_ready), 32'b0100);

        // Reset mid-stream with a held beat and rr_ptr=2
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'h0);
        step();
        chk_out("midrst", 1'b0, 2'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ptr0", 32'(in_ready), 32'b0001);

        // N=3: sel=3 is out of range, RR wraps 2->0
        rst3_n = 1'b1;
        #1;
        chk("n3_sel3_ready", 32'(in_ready3), 32'h0);
        step();
        chk("n3_sel3_valid", 32'(out_valid3), 32'h0);
        mode3 = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("n3_rr_ready", 32'(in_ready3), 32'(3'b001 << (i % 3)));
            step();
            chk("n3_rr_sel",  32'(out_sel3),  32'(i % 3));
            chk("n3_rr_data", out_data3,      32'hBEEF_0000 + 32'(i % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
